link_xfer_arbiter: RTL and testbench
====================================

Name: link_xfer_arbiter

Overview:
- Shares the single serial link peripheral between two byte-transfer requesters: port 0 (CPU-side shim) and port 1 (auxiliary engine, e.g. printer/debug host).
- Sequences each transfer as a link register write pair: SB, then SC with start=1.
- Waits for the link's transfer-complete interrupt, then returns the received byte to the granted requester.
- Sits between the requesters and the link's sel_sb/sel_sc/cpu_wr_n/sb_in/sc_* inputs.

Parameters:
- TIMEOUT, default 131071: cycles allowed in BUSY before abort; used only when LINK_TIMEOUT_EN is defined.
- TO_W, default 17: width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  system clock; only clock.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 transfer request; level, held until done0.
- tx0  in  8  port 0 byte to send.
- int_clk0  in  1  port 0: 1=internal clock (master), 0=external.
- done0  out  1  one-cycle pulse: port 0 transfer finished.
- rx0  out  8  port 0 received byte; valid with done0, held until the next port 0 done.
- req1, tx1, int_clk1, done1, rx1: same as port 0, for port 1.
- err  out  1  one-cycle pulse coincident with done0/done1 when the transfer aborted; always 0 without LINK_TIMEOUT_EN.
- busy  out  1  high in any state except IDLE.
- sel_sb  out  1  link SB write select.
- sel_sc  out  1  link SC write select.
- cpu_wr_n  out  1  link write strobe, active low.
- sb_out  out  8  data to the link sb_in.
- sc_start_out  out  1  to the link sc_start_in.
- sc_int_clock_out  out  1  to the link sc_int_clock_in.
- link_sb  in  8  link SB shift register contents.
- link_irq  in  1  link serial_irq; one-cycle pulse.

Behaviour:
- All outputs are registered.
- Reset values:
  - sel_sb=0, sel_sc=0, cpu_wr_n=1.
  - sb_out=0, sc_start_out=0, sc_int_clock_out=0.
  - done0=0, done1=0, err=0, busy=0, rx0=0, rx1=0.
  - State IDLE, last_grant=1, so port 0 wins the first contention.
- States: IDLE -> WR_SB -> WR_SC -> BUSY -> DONE -> IDLE. Optional ABORT is entered only from BUSY.
- IDLE:
  - If any req is high, grant it. If both are high, grant the port that is not last_grant (round robin).
  - Latch gnt, tx and int_clk of the granted port, then go to WR_SB.
- WR_SB (exactly 1 cycle): sel_sb=1, cpu_wr_n=0, sb_out=tx latched.
- WR_SC (exactly 1 cycle): sel_sc=1, cpu_wr_n=0, sc_start_out=1, sc_int_clock_out=int_clk latched.
- BUSY:
  - Selects are 0 and cpu_wr_n=1.
  - On the cycle link_irq=1, capture link_sb into the granted port's rx and go to DONE.
- DONE (1 cycle): pulse done of the granted port, set last_grant=gnt, return to IDLE.
- Latency, internal clock: request seen in IDLE -> WR_SB at +1 -> WR_SC at +2. done follows the link_irq cycle by 1.
- Minimum gap between back-to-back transfers: one IDLE cycle.
- The requester is sampled only in IDLE. tx/int_clk changes or req deassertion after grant are ignored; the transfer completes and done still pulses.
- link_irq outside BUSY is ignored.
- link_irq is ignored during WR_SB/WR_SC; the link ignores stale completion while being written.
- The ungranted request is held pending and served at the next IDLE. No starvation: alternation is guaranteed under continuous contention.
- rst mid-transfer returns to IDLE with reset outputs. No done pulse is issued for the aborted transfer; the link is reset in parallel by its own rst.

Optional Feature:
- Macro LINK_TIMEOUT_EN.
- When defined:
  - A TO_W-bit counter is cleared on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT with no link_irq, go to ABORT.
  - ABORT (1 cycle): sel_sc=1, cpu_wr_n=0, sc_start_out=0, sc_int_clock_out=latched value.
  - Then go to DONE with err=1 and rx=link_sb (partial data).
  - If link_irq and the timeout occur in the same cycle, link_irq wins: normal completion, err=0.
- When undefined:
  - BUSY waits indefinitely; this is needed for an external-clock slave with no partner.
  - No counter logic; err is tied to 0.

Test Plan:
- req0=1, tx0=0xA5, int_clk0=1; model link_irq 9 cycles after WR_SC with link_sb=0x3C -> WR_SB with sb_out=0xA5, then WR_SC with sc_start_out=1 and sc_int_clock_out=1; done0 one cycle after irq; rx0=0x3C; err=0.
- req0 and req1 both high continuously, tx0=0x11, tx1=0x22 -> grants alternate 0,1,0,1; sb_out sequence 0x11,0x22,0x11,0x22; each done pulses only on its own port.
- req1 granted, then req1 dropped during BUSY; irq with link_sb=0x7E -> done1 still pulses, rx1=0x7E, rx0 unchanged.
- rst asserted in BUSY, then link_irq 2 cycles later -> all outputs at reset values, no done pulse, irq ignored, busy=0.
- LINK_TIMEOUT_EN, TIMEOUT=16, int_clk0=0, no irq -> after 16 BUSY cycles one ABORT cycle (sel_sc=1, sc_start_out=0), then done0=1 and err=1 in the same cycle.
- LINK_TIMEOUT_EN, link_irq on the exact timeout cycle -> normal DONE, err=0, no ABORT cycle.

Source files
------------

// File: rtl/link_xfer_arbiter.sv
// link_xfer_arbiter: shares one serial link between two byte-transfer requesters.
// Optional BUSY watchdog (abort after TIMEOUT cycles) is built when LINK_TIMEOUT_EN is defined.
module link_xfer_arbiter #(
  parameter int TIMEOUT = 131071,
  parameter int TO_W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] tx0,
  input  logic       int_clk0,
  output logic       done0,
  output logic [7:0] rx0,
  input  logic       req1,
  input  logic [7:0] tx1,
  input  logic       int_clk1,
  output logic       done1,
  output logic [7:0] rx1,
  output logic       err,
  output logic       busy,
  output logic       sel_sb,
  output logic       sel_sc,
  output logic       cpu_wr_n,
  output logic [7:0] sb_out,
  output logic       sc_start_out,
  output logic       sc_int_clock_out,
  input  logic [7:0] link_sb,
  input  logic       link_irq
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_SB = 3'd1,
    ST_WR_SC = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  state_t     state_r;
  logic       gnt_r;
  logic       last_grant_r;
  logic [7:0] tx_r;
  logic       int_clk_r;

  logic       any_req_s;
  logic       grant_s;
  logic [7:0] tx_sel_s;
  logic       int_clk_sel_s;

`ifdef LINK_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_r;
`endif

  // The watchdog counter must be able to hold TIMEOUT.
  if (TIMEOUT >= 2 ** TO_W) begin : g_bad_timeout
    $error("link_xfer_arbiter: TIMEOUT does not fit in TO_W bits");
  end

  // Round-robin grant: on contention the port that was not served last wins.
  always_comb begin
    any_req_s     = req0 | req1;
    grant_s       = 1'b0;
    tx_sel_s      = 8'h00;
    int_clk_sel_s = 1'b0;
    if (req0 && req1) begin
      grant_s = ~last_grant_r;
    end else if (req1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      tx_sel_s      = tx1;
      int_clk_sel_s = int_clk1;
    end else begin
      tx_sel_s      = tx0;
      int_clk_sel_s = int_clk0;
    end
  end

  // Transfer sequencer; every output is registered together with the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      gnt_r            <= 1'b0;
      last_grant_r     <= 1'b1;
      tx_r             <= 8'h00;
      int_clk_r        <= 1'b0;
      done0            <= 1'b0;
      done1            <= 1'b0;
      rx0              <= 8'h00;
      rx1              <= 8'h00;
      err              <= 1'b0;
      busy             <= 1'b0;
      sel_sb           <= 1'b0;
      sel_sc           <= 1'b0;
      cpu_wr_n         <= 1'b1;
      sb_out           <= 8'h00;
      sc_start_out     <= 1'b0;
      sc_int_clock_out <= 1'b0;
`ifdef LINK_TIMEOUT_EN
      to_cnt_r         <= {TO_W{1'b0}};
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r   <= ST_WR_SB;
            gnt_r     <= grant_s;
            tx_r      <= tx_sel_s;
            int_clk_r <= int_clk_sel_s;
            busy      <= 1'b1;
            sel_sb    <= 1'b1;
            cpu_wr_n  <= 1'b0;
            sb_out    <= tx_sel_s;
          end else begin
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            sel_sb   <= 1'b0;
            sel_sc   <= 1'b0;
            cpu_wr_n <= 1'b1;
          end
        end
        ST_WR_SB: begin
          state_r          <= ST_WR_SC;
          sel_sb           <= 1'b0;
          sel_sc           <= 1'b1;
          cpu_wr_n         <= 1'b0;
          sc_start_out     <= 1'b1;
          sc_int_clock_out <= int_clk_r;
        end
        ST_WR_SC: begin
          state_r      <= ST_BUSY;
          sel_sc       <= 1'b0;
          cpu_wr_n     <= 1'b1;
          sc_start_out <= 1'b0;
`ifdef LINK_TIMEOUT_EN
          to_cnt_r     <= {TO_W{1'b0}};
`endif
        end
        ST_BUSY: begin
          if (link_irq) begin
            // Completion beats a coincident timeout.
            state_r <= ST_DONE;
            if (gnt_r) begin
              rx1   <= link_sb;
              done1 <= 1'b1;
            end else begin
              rx0   <= link_sb;
              done0 <= 1'b1;
            end
          end else begin
`ifdef LINK_TIMEOUT_EN
            if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
              state_r          <= ST_ABORT;
              sel_sc           <= 1'b1;
              cpu_wr_n         <= 1'b0;
              sc_start_out     <= 1'b0;
              sc_int_clock_out <= int_clk_r;
            end else begin
              state_r  <= ST_BUSY;
              to_cnt_r <= to_cnt_r + TO_W'(1);
            end
`else
            state_r <= ST_BUSY;
`endif
          end
        end
`ifdef LINK_TIMEOUT_EN
        ST_ABORT: begin
          // SC rewritten with start=0 stops the link; hand back the partial byte.
          state_r  <= ST_DONE;
          sel_sc   <= 1'b0;
          cpu_wr_n <= 1'b1;
          err      <= 1'b1;
          if (gnt_r) begin
            rx1   <= link_sb;
            done1 <= 1'b1;
          end else begin
            rx0   <= link_sb;
            done0 <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          state_r      <= ST_IDLE;
          last_grant_r <= gnt_r;
          busy         <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          busy         <= 1'b0;
          sel_sb       <= 1'b0;
          sel_sc       <= 1'b0;
          cpu_wr_n     <= 1'b1;
          sc_start_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_xfer_arbiter.sv
// Scoreboard bench for link_xfer_arbiter: stimulus pushes expected link writes and
// completions into queues, a negedge monitor pops and compares them.
module tb_link_xfer_arbiter;

`ifdef LINK_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 131071;
`endif

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [7:0] tx0, tx1;
  logic       int_clk0, int_clk1;
  logic       done0, done1;
  logic [7:0] rx0, rx1;
  logic       err, busy, sel_sb, sel_sc, cpu_wr_n;
  logic [7:0] sb_out;
  logic       sc_start_out, sc_int_clock_out;
  logic [7:0] link_sb;
  logic       link_irq;

  int n_cmp  = 0;
  int n_fail = 0;
  int abort_seen = 0;

  logic [7:0] sb_q[$];
  logic       sc_q[$];
  logic [9:0] done_q[$];   // {port, err, rx}

  link_xfer_arbiter #(.TIMEOUT(TB_TIMEOUT), .TO_W(17)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .tx0(tx0), .int_clk0(int_clk0), .done0(done0), .rx0(rx0),
    .req1(req1), .tx1(tx1), .int_clk1(int_clk1), .done1(done1), .rx1(rx1),
    .err(err), .busy(busy), .sel_sb(sel_sb), .sel_sc(sel_sc), .cpu_wr_n(cpu_wr_n),
    .sb_out(sb_out), .sc_start_out(sc_start_out), .sc_int_clock_out(sc_int_clock_out),
    .link_sb(link_sb), .link_irq(link_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_xfer(input logic port, input logic [7:0] tx, input logic clk_int,
                           input logic [7:0] rx, input logic e);
    sb_q.push_back(tx);
    sc_q.push_back(clk_int);
    done_q.push_back({port, e, rx});
  endtask

  task automatic wait_wrsc();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sel_sc && !cpu_wr_n && sc_start_out) begin
        ok = 1'b1;
        break;
      end
    end
    check("wrsc_seen", 32'(ok), 32'd1);
  endtask

  // One-cycle link completion pulse; ends at the negedge of the DONE cycle.
  task automatic pulse_irq(input logic [7:0] data, input logic port);
    @(posedge clk); #1;
    link_sb  = data;
    link_irq = 1'b1;
    @(posedge clk); #1;
    link_irq = 1'b0;
    @(negedge clk);
    check("done_latency", 32'(port ? done1 : done0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {busy, sel_sb, sel_sc, cpu_wr_n, sc_start_out, sc_int_clock_out,
                 done0, done1, err, sb_out, rx0, rx1},
          {9'b000100000, 8'h00, 8'h00, 8'h00});
  endtask

  // Monitor: compares every link write and every completion against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (sel_sb && !cpu_wr_n) begin
        if (sb_q.size() == 0) check("sb_unexpected", 32'(sb_out), 32'hFFFF_FFFF);
        else check("sb_out", 32'(sb_out), 32'(sb_q.pop_front()));
      end
      if (sel_sc && !cpu_wr_n && sc_start_out) begin
        if (sc_q.size() == 0) check("sc_unexpected", 32'(sc_int_clock_out), 32'hFFFF_FFFF);
        else check("sc_int_clock", 32'(sc_int_clock_out), 32'(sc_q.pop_front()));
      end
      if (sel_sc && !cpu_wr_n && !sc_start_out) abort_seen++;
      if (done0 || done1) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", {30'd0, done1, done0}, 32'd0);
        end else begin
          logic [9:0] e;
          e = done_q.pop_front();
          check("done_port", {30'd0, done1, done0}, e[9] ? 32'd2 : 32'd1);
          check("rx", 32'(e[9] ? rx1 : rx0), 32'(e[7:0]));
          check("err", 32'(err), 32'(e[8]));
        end
      end else if (err) begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cont_rx [4];
    int n;
    int ab0;
    logic seen;
    cont_rx[0] = 8'h81; cont_rx[1] = 8'h42; cont_rx[2] = 8'hC3; cont_rx[3] = 8'h24;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; tx0 = 8'h00; tx1 = 8'h00;
    int_clk0 = 1'b0; int_clk1 = 1'b0; link_sb = 8'h00; link_irq = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_values");

    // Single port-0 transfer with latency checks.
    @(posedge clk); #1;
    req0 = 1'b1; tx0 = 8'hA5; int_clk0 = 1'b1;
    push_xfer(1'b0, 8'hA5, 1'b1, 8'h3C, 1'b0);
    @(negedge clk);
    check("idle_before_sample", 32'(busy), 32'd0);
    @(negedge clk);
    check("lat_wr_sb", {30'd0, sel_sb, busy}, 32'd3);
    @(negedge clk);
    check("lat_wr_sc", {30'd0, sel_sc, sc_start_out}, 32'd3);
    repeat (8) @(posedge clk);
    pulse_irq(8'h3C, 1'b0);
    req0 = 1'b0;

    // Port 1 drops its request in BUSY; an irq during WR_SB must be ignored.
    @(posedge clk); #1;
    req1 = 1'b1; tx1 = 8'h5A; int_clk1 = 1'b0;
    push_xfer(1'b1, 8'h5A, 1'b0, 8'h7E, 1'b0);
    @(posedge clk); #1;
    link_sb = 8'h00; link_irq = 1'b1;
    @(posedge clk); #1;
    link_irq = 1'b0;
    wait_wrsc();
    @(posedge clk); #1;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    pulse_irq(8'h7E, 1'b1);
    check("rx0_unchanged", 32'(rx0), 32'h3C);

    // Continuous contention: grants alternate 0,1,0,1.
    req0 = 1'b1; req1 = 1'b1; tx0 = 8'h11; tx1 = 8'h22; int_clk0 = 1'b1; int_clk1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_xfer(1'b0, 8'h11, 1'b1, cont_rx[i], 1'b0);
      else            push_xfer(1'b1, 8'h22, 1'b0, cont_rx[i], 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      wait_wrsc();
      repeat (2) @(posedge clk);
      pulse_irq(cont_rx[i], (i % 2) == 1);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset in BUSY, late irq must not produce a done.
    @(posedge clk); #1;
    req0 = 1'b1; tx0 = 8'h99; int_clk0 = 1'b1;
    sb_q.push_back(8'h99);
    sc_q.push_back(1'b1);
    wait_wrsc();
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid_busy");
    @(posedge clk); #1;
    link_sb = 8'hEE; link_irq = 1'b1;
    @(posedge clk); #1;
    link_irq = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("irq_after_reset");

`ifdef LINK_TIMEOUT_EN
    // Timeout: 16 BUSY cycles, one ABORT cycle, then done0 with err.
    @(posedge clk); #1;
    req0 = 1'b1; tx0 = 8'h33; int_clk0 = 1'b0; link_sb = 8'h5C;
    push_xfer(1'b0, 8'h33, 1'b0, 8'h5C, 1'b1);
    wait_wrsc();
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (sel_sc && !cpu_wr_n && !sc_start_out) seen = 1'b1;
    end
    check("abort_latency", 32'(n), 32'd17);
    @(negedge clk);
    check("abort_done_err", {30'd0, done0, err}, 32'd3);
    req0 = 1'b0;

    // irq on the exact timeout cycle completes normally.
    ab0 = abort_seen;
    @(posedge clk); #1;
    req0 = 1'b1; tx0 = 8'h44; int_clk0 = 1'b1;
    push_xfer(1'b0, 8'h44, 1'b1, 8'hB7, 1'b0);
    wait_wrsc();
    repeat (15) @(posedge clk);
    pulse_irq(8'hB7, 1'b0);
    req0 = 1'b0;
    check("no_abort_on_irq", 32'(abort_seen - ab0), 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("sb_q_drained", 32'(sb_q.size()), 32'd0);
    check("sc_q_drained", 32'(sc_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
